collect_sequencer: RTL and testbench
====================================

Name: collect_sequencer

Overview:
Sequences one instrument collection cycle on the 50 MHz domain. The cycle runs start → settle delay → timed collection window → count readout handshake. A clock-enable prescaler sets the timebase; no derived clocks are used. During the window the block counts qualified event pulses and hands the total downstream over a valid/ack interface. It sits between the command/housekeeping logic, which issues start/abort and the lengths, and the collection datapath, which is gated by collect_enable.

Parameters:
DIV_BITS, 8, prescaler width; one tick = 2^DIV_BITS clk50 cycles (20 ns × 256 = 5.12 us at default)
CNT_W, 16, width of event counter and count_out

Ports:
clk50  input  1  system clock, 50 MHz; the only clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  single-cycle request to begin a cycle; honoured only in IDLE
abort  input  1  level/pulse; forces return to IDLE from any state
settle_len  input  15  settle delay in ticks; sampled on accepted start
collect_len  input  16  window length in ticks; sampled on accepted start; 0 treated as 1
event_in  input  1  synchronous single-cycle event pulse
collect_enable  output  1  high exactly while window open
busy  output  1  high in any state except IDLE
count_out  output  CNT_W  event total; stable while count_valid
count_valid  output  1  readout handshake valid
count_ack  input  1  readout handshake acknowledge
overflow  output  1  sticky: event count saturated this cycle
done  output  1  one-cycle pulse on completed handshake

Behaviour:
- All state updates on posedge clk50. rst_n low at an edge: state=IDLE, prescaler=0, tick_cnt=0, event count=0. All outputs 0: collect_enable, busy, count_out, count_valid, overflow, done.
- States: IDLE, SETTLE, COLLECT, READOUT. All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- Prescaler: DIV_BITS-bit counter, runs only in SETTLE/COLLECT, cleared on every state entry. tick = (prescaler == all ones). tick_cnt increments on tick and is cleared on every state entry.
- IDLE: start=1 and abort=0 → SETTLE. On that edge: latch settle_len and collect_len (0→1), clear event count, clear overflow. Treat settle_len==0 as immediate: go directly IDLE→COLLECT on the start edge.
- SETTLE → COLLECT on the edge where tick=1 and tick_cnt+1 == settle_len_l. Settle therefore lasts exactly settle_len_l × 2^DIV_BITS cycles.
- COLLECT: collect_enable=1. Count event_in=1 each cycle in COLLECT, including the final cycle. Do not count events in any other state.
  - Count saturates at all ones.
  - An event arriving at saturation sets overflow, which stays set until the next accepted start or reset.
- COLLECT → READOUT on the edge where tick=1 and tick_cnt+1 == collect_len_l. collect_enable is high for exactly collect_len_l × 2^DIV_BITS cycles.
- READOUT: count_valid=1 and count_out=final count, both held until acknowledged. count_ack=1 → IDLE and done=1 for one cycle. count_ack outside READOUT is ignored.
- busy=1 in SETTLE, COLLECT, READOUT.
- start while busy is ignored and not queued.
- abort=1 in any non-IDLE state → IDLE next edge. collect_enable, count_valid and busy drop on that edge; no done pulse. count_out and overflow keep their last values.
- abort and start together in IDLE: abort wins, stay IDLE.
- abort and count_ack together in READOUT: abort wins, no done pulse.
- Reset asserted mid-operation: full reset values on that edge, regardless of state.
- tick_cnt is 16 bits and cannot wrap, because the exit compares fire first.

Test Plan:
- DIV_BITS=2, settle_len=3, collect_len=5, start at cycle 0 → collect_enable rises at edge 12, stays high 20 cycles, count_valid rises on the edge collect_enable falls; busy high throughout.
- Same config, event_in pulses at 4 cycles inside the window plus 2 during settle and 2 during READOUT → count_out=4, overflow=0; count_ack → done one cycle, busy=0 next edge.
- CNT_W=4, 20 events in window → count_out=15, overflow=1. New start → overflow=0, count cleared.
- settle_len=0, collect_len=0 → collect_enable on the edge after start, high exactly 2^DIV_BITS cycles.
- abort mid-COLLECT → collect_enable, busy=0 next edge, no done. start+abort same cycle in IDLE → stays IDLE. start during COLLECT → ignored.
- rst_n low for one edge during READOUT → all outputs 0, IDLE. A following start runs a normal cycle.

Source files
------------

// File: rtl/collect_sequencer_if.sv
// Readout handshake between the collection sequencer and its downstream consumer.
// The sequencer owns the count, its valid flag, the overflow flag and the done pulse;
// the consumer answers with count_ack.
interface collect_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             count_ack;
    logic             overflow;
    logic             done;

    modport master (
        output count_out,
        output count_valid,
        output overflow,
        output done,
        input  count_ack
    );

    modport slave (
        input  count_out,
        input  count_valid,
        input  overflow,
        input  done,
        output count_ack
    );
endinterface

// File: rtl/collect_sequencer.sv
// Instrument collection cycle sequencer on the 50 MHz domain.
// A cycle runs IDLE -> SETTLE -> COLLECT -> READOUT -> IDLE. Timing comes from a
// clock-enable prescaler: one tick every 2^DIV_BITS clk50 cycles, no derived clocks.
// During COLLECT, qualified event pulses are counted (saturating); the total is
// handed downstream on a valid/ack handshake. Every output is a register loaded
// from the next-state decode, so outputs change on the same edge as the state.
module collect_sequencer #(
    parameter int DIV_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [14:0] settle_len,
    input  logic [15:0] collect_len,
    input  logic        event_in,
    output logic        collect_enable,
    output logic        busy,
    collect_sequencer_if.master rd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COLLECT = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [DIV_BITS-1:0]  prescaler;
    logic [15:0]          tick_cnt;
    logic [14:0]          settle_len_l;
    logic [15:0]          collect_len_l;

    logic [CNT_W-1:0]     count;
    logic                 count_valid_q;
    logic                 overflow_q;
    logic                 done_q;

    logic                 timing;
    logic                 tick;
    logic                 settle_end;
    logic                 collect_end;
    logic                 start_ok;
    logic                 handshake;

    // Timebase strobes, exit conditions and handshake qualifiers for this cycle.
    always_comb begin
        timing      = (state == SETTLE) || (state == COLLECT);
        tick        = timing && (prescaler == '1);
        // The exit compares look one tick ahead, so tick_cnt never needs to wrap.
        settle_end  = tick && ((tick_cnt + 16'd1) == {1'b0, settle_len_l});
        collect_end = tick && ((tick_cnt + 16'd1) == collect_len_l);
        start_ok    = (state == IDLE) && start && !abort;
        // abort dominates a simultaneous acknowledge: no done pulse in that case.
        handshake   = (state == READOUT) && rd.count_ack && !abort;
    end

    // Next-state decode; abort returns to IDLE from every busy state.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    // A zero settle length skips SETTLE entirely.
                    state_next = (settle_len == 15'd0) ? COLLECT : SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_end) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (collect_end) begin
                    state_next = READOUT;
                end
            end
            READOUT: begin
                if (abort || handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, timebase, length latches, event counter and registered outputs.
    always_ff @(posedge clk50) begin
        // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
        if (!rst_n) begin
            state          <= IDLE;
            prescaler      <= '0;
            tick_cnt       <= '0;
            settle_len_l   <= '0;
            collect_len_l  <= '0;
            count          <= '0;
            overflow_q     <= 1'b0;
            collect_enable <= 1'b0;
            busy           <= 1'b0;
            count_valid_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_next;

            // Outputs decoded from the next state so they move with the state.
            collect_enable <= (state_next == COLLECT);
            busy           <= (state_next != IDLE);
            count_valid_q  <= (state_next == READOUT);
            done_q         <= handshake;

            // Timebase restarts on every state entry and only runs while timing.
            if (state_next != state) begin
                prescaler <= '0;
                tick_cnt  <= '0;
            end else if (timing) begin
                prescaler <= prescaler + 1'b1;
                if (tick) begin
                    tick_cnt <= tick_cnt + 16'd1;
                end
            end

            // Accepted start latches the lengths and clears the previous result.
            if (start_ok) begin
                settle_len_l  <= settle_len;
                collect_len_l <= (collect_len == 16'd0) ? 16'd1 : collect_len;
                count         <= '0;
                overflow_q    <= 1'b0;
            end else if ((state == COLLECT) && event_in) begin
                // Saturate at all ones; an event lost to saturation flags overflow.
                if (count == '1) begin
                    overflow_q <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign rd.count_out   = count;
    assign rd.count_valid = count_valid_q;
    assign rd.overflow    = overflow_q;
    assign rd.done        = done_q;

endmodule

// File: tb/tb_collect_sequencer.sv
// Directed bench for collect_sequencer with DIV_BITS=2 (tick every 4 cycles) and
// CNT_W=4 so saturation is reachable inside a short window. A table of
// {inputs, hold cycles, expected outputs} records is applied in a loop, followed
// by hand-written sequences for window timing and abort/ack priority.
module tb_collect_sequencer;

    localparam int DIV_BITS = 2;
    localparam int CNT_W    = 4;

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [14:0] settle_len;
    logic [15:0] collect_len;
    logic        event_in;
    logic        collect_enable;
    logic        busy;

    always #10 clk50 = ~clk50;

    collect_sequencer_if #(.CNT_W(CNT_W)) rd ();

    collect_sequencer #(
        .DIV_BITS(DIV_BITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk50         (clk50),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .settle_len    (settle_len),
        .collect_len   (collect_len),
        .event_in      (event_in),
        .collect_enable(collect_enable),
        .busy          (busy),
        .rd            (rd)
    );

    typedef struct {
        string            name;
        logic             rst_n;
        logic             start;
        logic             abort;
        logic [14:0]      settle;
        logic [15:0]      collect;
        logic             ev;
        logic             ack;
        int               cycles;
        logic             ce;
        logic             bz;
        logic             valid;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             done;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic s, input logic a,
                                input logic [14:0] sl, input logic [15:0] cl, input logic ev,
                                input logic ack, input int cyc, input logic ce, input logic bz,
                                input logic vl, input logic [CNT_W-1:0] cnt, input logic ovf,
                                input logic dn);
        vec_t v;
        v.name = name; v.rst_n = r; v.start = s; v.abort = a; v.settle = sl; v.collect = cl;
        v.ev = ev; v.ack = ack; v.cycles = cyc; v.ce = ce; v.bz = bz; v.valid = vl;
        v.cnt = cnt; v.ovf = ovf; v.done = dn;
        return v;
    endfunction

    // Called at a negedge: drive inputs, hold for v.cycles edges, check at the next negedge.
    task automatic apply(input vec_t v);
        rst_n       = v.rst_n;
        start       = v.start;
        abort       = v.abort;
        settle_len  = v.settle;
        collect_len = v.collect;
        event_in    = v.ev;
        rd.count_ack = v.ack;
        repeat (v.cycles) @(posedge clk50);
        @(negedge clk50);
        check({v.name, ".collect_enable"}, collect_enable, v.ce);
        check({v.name, ".busy"},           busy,           v.bz);
        check({v.name, ".count_valid"},    rd.count_valid, v.valid);
        check({v.name, ".count_out"},      rd.count_out,   v.cnt);
        check({v.name, ".overflow"},       rd.overflow,    v.ovf);
        check({v.name, ".done"},           rd.done,        v.done);
    endtask

    task automatic idle_inputs();
        rst_n        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        event_in     = 1'b0;
        rd.count_ack = 1'b0;
    endtask

    initial begin
        int rise_edge;
        int valid_edge;
        int ce_cycles;
        bit busy_drop;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; event_in = 1'b0;
        settle_len = '0; collect_len = '0; rd.count_ack = 1'b0;
        @(negedge clk50);

        //                 name            rst st ab  settle coll ev ack cyc  ce bz vl cnt ovf dn
        // Nominal cycle settle=3, collect=5: start is edge 0, window edges 12..31.
        vecs.push_back(mk("reset",          0, 0, 0,  0,     0,   0, 0,  2,   0, 0, 0, 0,  0,  0));
        vecs.push_back(mk("idle",           1, 0, 0,  0,     0,   0, 0,  1,   0, 0, 0, 0,  0,  0));
        vecs.push_back(mk("start",          1, 1, 0,  3,     5,   0, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("settle_ev1",     1, 0, 0,  3,     5,   1, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("settle_gap",     1, 0, 0,  3,     5,   0, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("settle_ev2",     1, 0, 0,  3,     5,   1, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("settle_e11",     1, 0, 0,  3,     5,   0, 0,  8,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("window_e12",     1, 0, 0,  3,     5,   0, 0,  1,   1, 1, 0, 0,  0,  0));
        vecs.push_back(mk("win_ev_a",       1, 0, 0,  3,     5,   1, 0,  1,   1, 1, 0, 1,  0,  0));
        vecs.push_back(mk("win_gap_a",      1, 0, 0,  3,     5,   0, 0,  5,   1, 1, 0, 1,  0,  0));
        vecs.push_back(mk("win_ev_bc",      1, 0, 0,  3,     5,   1, 0,  2,   1, 1, 0, 3,  0,  0));
        vecs.push_back(mk("win_e31",        1, 0, 0,  3,     5,   0, 0, 11,   1, 1, 0, 3,  0,  0));
        vecs.push_back(mk("win_last_ev",    1, 0, 0,  3,     5,   1, 0,  1,   0, 1, 1, 4,  0,  0));
        vecs.push_back(mk("readout_ev",     1, 0, 0,  3,     5,   1, 0,  2,   0, 1, 1, 4,  0,  0));
        vecs.push_back(mk("readout_hold",   1, 0, 0,  3,     5,   0, 0,  3,   0, 1, 1, 4,  0,  0));
        vecs.push_back(mk("ack",            1, 0, 0,  3,     5,   0, 1,  1,   0, 0, 0, 4,  0,  1));
        vecs.push_back(mk("ack_in_idle",    1, 0, 0,  3,     5,   0, 1,  1,   0, 0, 0, 4,  0,  0));
        // Saturation: settle=1, collect=5, event every window cycle (20 events).
        vecs.push_back(mk("sat_start",      1, 1, 0,  1,     5,   0, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("sat_settle",     1, 0, 0,  1,     5,   0, 0,  3,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("sat_window",     1, 0, 0,  1,     5,   0, 0,  1,   1, 1, 0, 0,  0,  0));
        vecs.push_back(mk("sat_15ev",       1, 0, 0,  1,     5,   1, 0, 15,   1, 1, 0, 15, 0,  0));
        vecs.push_back(mk("sat_16th",       1, 0, 0,  1,     5,   1, 0,  1,   1, 1, 0, 15, 1,  0));
        vecs.push_back(mk("sat_end",        1, 0, 0,  1,     5,   1, 0,  4,   0, 1, 1, 15, 1,  0));
        vecs.push_back(mk("sat_ack",        1, 0, 0,  1,     5,   0, 1,  1,   0, 0, 0, 15, 1,  1));
        // New start clears count/overflow; start mid-window ignored; abort in COLLECT.
        vecs.push_back(mk("clr_start",      1, 1, 0,  2,     1,   0, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("clr_settle",     1, 0, 0,  2,     1,   0, 0,  7,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("clr_window",     1, 0, 0,  2,     1,   0, 0,  1,   1, 1, 0, 0,  0,  0));
        vecs.push_back(mk("start_in_win",   1, 1, 0,  0,     9,   1, 0,  1,   1, 1, 0, 1,  0,  0));
        vecs.push_back(mk("abort_win",      1, 0, 1,  0,     9,   0, 0,  1,   0, 0, 0, 1,  0,  0));
        vecs.push_back(mk("start_abort",    1, 1, 1,  0,     9,   0, 0,  1,   0, 0, 0, 1,  0,  0));
        vecs.push_back(mk("not_queued",     1, 0, 0,  0,     9,   0, 0,  2,   0, 0, 0, 1,  0,  0));
        // Zero lengths: window on the start edge, exactly one tick long.
        vecs.push_back(mk("zero_start",     1, 1, 0,  0,     0,   0, 0,  1,   1, 1, 0, 0,  0,  0));
        vecs.push_back(mk("zero_win",       1, 0, 0,  0,     0,   1, 0,  3,   1, 1, 0, 3,  0,  0));
        vecs.push_back(mk("zero_end",       1, 0, 0,  0,     0,   0, 0,  1,   0, 1, 1, 3,  0,  0));
        // Reset during READOUT, then a normal cycle settle=1, collect=1.
        vecs.push_back(mk("rst_readout",    0, 0, 0,  0,     0,   0, 0,  1,   0, 0, 0, 0,  0,  0));
        vecs.push_back(mk("post_start",     1, 1, 0,  1,     1,   0, 0,  1,   0, 1, 0, 0,  0,  0));
        vecs.push_back(mk("post_window",    1, 0, 0,  1,     1,   0, 0,  4,   1, 1, 0, 0,  0,  0));
        vecs.push_back(mk("post_readout",   1, 0, 0,  1,     1,   0, 0,  4,   0, 1, 1, 0,  0,  0));
        vecs.push_back(mk("post_ack",       1, 0, 0,  1,     1,   0, 1,  1,   0, 0, 0, 0,  0,  1));
        vecs.push_back(mk("post_idle",      1, 0, 0,  1,     1,   0, 0,  1,   0, 0, 0, 0,  0,  0));

        foreach (vecs[i]) apply(vecs[i]);

        // Window timing measured edge by edge: settle=3, collect=5, start on edge 0.
        idle_inputs();
        settle_len  = 15'd3;
        collect_len = 16'd5;
        start       = 1'b1;
        @(negedge clk50);
        start      = 1'b0;
        rise_edge  = -1;
        valid_edge = -1;
        ce_cycles  = 0;
        busy_drop  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk50);
            if (collect_enable && rise_edge < 0) rise_edge = k;
            if (collect_enable) ce_cycles++;
            if (rd.count_valid && valid_edge < 0) valid_edge = k;
            if (!busy) busy_drop = 1'b1;
        end
        check("timing.ce_rise_edge",  rise_edge,  12);
        check("timing.ce_cycles",     ce_cycles,  20);
        check("timing.valid_edge",    valid_edge, 32);
        check("timing.busy_dropped",  busy_drop,  0);
        rd.count_ack = 1'b1;
        @(negedge clk50);
        rd.count_ack = 1'b0;
        check("timing.done", rd.done, 1);

        // abort together with count_ack in READOUT: abort wins, no done pulse.
        settle_len  = 15'd0;
        collect_len = 16'd1;
        start       = 1'b1;
        event_in    = 1'b1;
        @(negedge clk50);
        start = 1'b0;
        for (int k = 0; k < 50 && !rd.count_valid; k++) @(negedge clk50);
        event_in = 1'b0;
        check("abort_ack.valid_seen", rd.count_valid, 1);
        check("abort_ack.count",      rd.count_out,   4);
        abort        = 1'b1;
        rd.count_ack = 1'b1;
        @(negedge clk50);
        abort        = 1'b0;
        rd.count_ack = 1'b0;
        check("abort_ack.done",  rd.done,        0);
        check("abort_ack.busy",  busy,           0);
        check("abort_ack.valid", rd.count_valid, 0);
        check("abort_ack.count_kept", rd.count_out, 4);
        @(negedge clk50);
        check("abort_ack.done_after", rd.done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
